// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    localparam int ADDRESS_WIDTH = 32;
    localparam int DATA_WIDTH    = 32;
    localparam int INSTR_BYTES   = 4;

    typedef enum logic {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [ADDRESS_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0]    instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// ROM, decode and redirect signals of the fetch controller, bundled as one port.
interface fetch_ctrl_if;
    import fetch_pkg::*;

    logic [ADDRESS_WIDTH-1:0] rom_a;
    logic [DATA_WIDTH-1:0]    rom_rd;
    logic                     instr_valid;
    logic                     instr_ready;
    logic [DATA_WIDTH-1:0]    instr;
    logic [ADDRESS_WIDTH-1:0] instr_pc;
    logic                     redirect;
    logic [ADDRESS_WIDTH-1:0] redirect_pc;
    logic                     fault;

    modport master (
        output rom_a, instr_valid, instr, instr_pc, fault,
        input  rom_rd, instr_ready, redirect, redirect_pc
    );

    modport slave (
        input  rom_a, instr_valid, instr, instr_pc, fault,
        output rom_rd, instr_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/fetch_queue.sv
// Two-entry prefetch FIFO; the head is registered and reads as zero when empty.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty
);

    logic [1:0]   count_q, count_d;
    fetch_entry_t e0_q, e0_d;
    fetch_entry_t e1_q, e1_d;
    logic         pop_fire;
    logic         push_fire;

    assign empty     = (count_q == 2'd0);
    assign full      = (count_q == 2'd2);
    assign head      = e0_q;
    assign pop_fire  = pop && !empty;
    assign push_fire = push && (!full || pop_fire);

    always_comb begin
        count_d = count_q;
        e0_d    = e0_q;
        e1_d    = e1_q;
        if (flush) begin
            count_d = 2'd0;
            e0_d    = '0;
            e1_d    = '0;
        end else begin
            case (count_q)
                2'd0: begin
                    if (push_fire) begin
                        e0_d    = push_entry;
                        count_d = 2'd1;
                    end
                end
                2'd1: begin
                    if (pop_fire && push_fire) begin
                        e0_d = push_entry;
                    end else if (pop_fire) begin
                        e0_d    = '0;
                        count_d = 2'd0;
                    end else if (push_fire) begin
                        e1_d    = push_entry;
                        count_d = 2'd2;
                    end
                end
                default: begin
                    // Full: a pop shifts the second entry forward, backfilled by any push.
                    if (pop_fire) begin
                        e0_d    = e1_q;
                        e1_d    = push_fire ? push_entry : '0;
                        count_d = push_fire ? 2'd2 : 2'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            count_q <= count_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: program counter, FETCH/FAULT sequencing and
// range check, feeding a two-entry prefetch queue toward decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                       ROM_BYTES = 28,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic      clk,
    input  logic      rst,
    fetch_ctrl_if.master bus
);

    fetch_state_t             state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
    logic [ADDRESS_WIDTH:0]   pc_last_byte;
    logic                     pc_legal;
    logic                     push;
    logic                     q_full;
    logic                     q_empty;
    fetch_entry_t             q_head;
    fetch_entry_t             push_entry;

    // One extra bit so pc + 3 near the top of the address space cannot wrap into range.
    assign pc_last_byte = {1'b0, pc_q} + (ADDRESS_WIDTH+1)'(INSTR_BYTES - 1);
    assign pc_legal     = (pc_last_byte < (ADDRESS_WIDTH+1)'(ROM_BYTES)) && (pc_q[1:0] == 2'b00);

    assign push_entry.pc    = pc_q;
    assign push_entry.instr = bus.rom_rd;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (bus.redirect) begin
            state_d = FETCH;
            pc_d    = bus.redirect_pc;
        end else begin
            case (state_q)
                FETCH: begin
                    if (!pc_legal) begin
                        state_d = FAULT;
                    end else if (!q_full || (bus.instr_ready && !q_empty)) begin
                        push = 1'b1;
                        pc_d = pc_q + ADDRESS_WIDTH'(INSTR_BYTES);
                    end
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    fetch_queue u_queue (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (bus.instr_ready),
        .flush      (bus.redirect),
        .head       (q_head),
        .full       (q_full),
        .empty      (q_empty)
    );

    assign bus.rom_a       = pc_q;
    assign bus.instr_valid = !q_empty;
    assign bus.instr       = q_head.instr;
    assign bus.instr_pc    = q_head.pc;
    assign bus.fault       = (state_q == FAULT);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: expected fetches queued on stimulus, checked on handshake.
module tb_fetch_ctrl;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    fetch_entry_t exp_q[$];

    fetch_ctrl_if bus();

    fetch_ctrl #(.ROM_BYTES(28), .RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < 32'd28 && a[1:0] == 2'b00)
            return 32'hC0DE_0000 | a;
        return 32'hBAD0_0000 | a;
    endfunction

    always_comb bus.rom_rd = rom_word(bus.rom_a);

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic exp_push(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = 32'hC0DE_0000 | pc;
        exp_q.push_back(e);
    endtask

    // Drive the inputs for the next edge; a head that will be accepted is checked now.
    task automatic cycle(input logic rdy, input logic redir, input logic [31:0] tgt);
        fetch_entry_t e;
        @(negedge clk);
        bus.instr_ready = rdy;
        bus.redirect    = redir;
        bus.redirect_pc = tgt;
        if (bus.instr_valid && rdy) begin
            chk("sb_expected_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_instr_pc", 64'(bus.instr_pc), 64'(e.pc));
                chk("sb_instr", 64'(bus.instr), 64'(e.instr));
                $display("deliver pc=%08h instr=%08h", bus.instr_pc, bus.instr);
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(bus.instr_valid), 64'd0);
        chk({tag, "_instr"}, 64'(bus.instr), 64'd0);
        chk({tag, "_pc"}, 64'(bus.instr_pc), 64'd0);
        chk({tag, "_fault"}, 64'(bus.fault), 64'd0);
        chk({tag, "_rom_a"}, 64'(bus.rom_a), 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst             = 1'b1;
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        bus.instr_ready = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;

        // Run straight through the 7-word ROM into FAULT.
        do_reset();
        for (int i = 0; i < 7; i++) exp_push(32'(4 * i));
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b0, '0);
            chk("t1_valid_stream", 64'(bus.instr_valid), 64'd1);
        end
        chk("t1_rom_a_at_limit", 64'(bus.rom_a), 64'd28);
        chk("t1_fault_not_yet", 64'(bus.fault), 64'd0);
        cycle(1'b1, 1'b0, '0);
        chk("t1_fault_set", 64'(bus.fault), 64'd1);
        chk("t1_valid_drained", 64'(bus.instr_valid), 64'd0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, '0);
        chk("t1_fault_held", 64'(bus.fault), 64'd1);
        chk("t1_pc_held", 64'(bus.rom_a), 64'd28);
        chk("t1_valid_idle", 64'(bus.instr_valid), 64'd0);
        chk("t1_all_delivered", 64'(exp_q.size()), 64'd0);

        // Back-pressure fills the queue and freezes pc, then drains without bubbles.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0);
        chk("t2_valid", 64'(bus.instr_valid), 64'd1);
        chk("t2_head_pc", 64'(bus.instr_pc), 64'd0);
        chk("t2_head_instr", 64'(bus.instr), 64'hC0DE_0000);
        chk("t2_rom_a_frozen", 64'(bus.rom_a), 64'd8);
        exp_push(32'd0); exp_push(32'd4); exp_push(32'd8);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, '0);
            chk("t2_valid_release", 64'(bus.instr_valid), 64'd1);
        end
        chk("t2_all_delivered", 64'(exp_q.size()), 64'd0);

        // Redirect to 0x10 with a full queue.
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0);
        cycle(1'b0, 1'b1, 32'h10);
        cycle(1'b1, 1'b0, '0);
        chk("t3_bubble", 64'(bus.instr_valid), 64'd0);
        chk("t3_rom_a_target", 64'(bus.rom_a), 64'h10);
        exp_push(32'h10); exp_push(32'h14);
        cycle(1'b1, 1'b0, '0);
        chk("t3_valid_after_2", 64'(bus.instr_valid), 64'd1);
        cycle(1'b1, 1'b0, '0);
        chk("t3_all_delivered", 64'(exp_q.size()), 64'd0);

        // Misaligned redirect faults, a redirect to 0 recovers.
        do_reset();
        cycle(1'b0, 1'b1, 32'h6);
        cycle(1'b1, 1'b0, '0);
        chk("t4_no_valid", 64'(bus.instr_valid), 64'd0);
        chk("t4_fault_not_yet", 64'(bus.fault), 64'd0);
        chk("t4_rom_a", 64'(bus.rom_a), 64'h6);
        cycle(1'b1, 1'b0, '0);
        chk("t4_fault_set", 64'(bus.fault), 64'd1);
        chk("t4_no_valid_fault", 64'(bus.instr_valid), 64'd0);
        cycle(1'b1, 1'b0, '0);
        chk("t4_pc_held", 64'(bus.rom_a), 64'h6);
        cycle(1'b1, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, '0);
        chk("t4_fault_cleared", 64'(bus.fault), 64'd0);
        chk("t4_rom_a_restart", 64'(bus.rom_a), 64'h0);
        exp_push(32'h0); exp_push(32'h4);
        cycle(1'b1, 1'b0, '0);
        chk("t4_resume_valid", 64'(bus.instr_valid), 64'd1);
        cycle(1'b1, 1'b0, '0);
        chk("t4_all_delivered", 64'(exp_q.size()), 64'd0);

        // Redirect in the same cycle as a pop and a would-be push.
        do_reset();
        exp_push(32'h0);
        cycle(1'b1, 1'b1, 32'h8);
        cycle(1'b1, 1'b0, '0);
        chk("t5_bubble", 64'(bus.instr_valid), 64'd0);
        chk("t5_rom_a_target", 64'(bus.rom_a), 64'h8);
        exp_push(32'h8); exp_push(32'hC);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk("t5_all_delivered", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset mid-cycle with a full queue.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0);
        chk("t6_full_valid", 64'(bus.instr_valid), 64'd1);
        chk("t6_full_rom_a", 64'(bus.rom_a), 64'd8);
        #3;
        rst = 1'b1;
        #1;
        chk_reset_outputs("t6_async");
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_push(32'h0); exp_push(32'h4);
        cycle(1'b1, 1'b0, '0);
        cycle(1'b1, 1'b0, '0);
        chk("t6_all_delivered", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
